shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It is the next generation of the 16-bit combinational logical shifter.
- Adds configurable width, arithmetic and rotate modes, and exact overflow detection.
- Registers one stage per shift-amount bit and carries a user tag with each operand.
- Uses a valid/ready handshake on both sides so it can sit between the operand-issue logic and the ALU result bus under backpressure.

---
 rtl/shift_pipe.sv | 192 +++++++++++++++++++
 tb/tb_shift_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//
// Pipelined barrel shifter for the ALU datapath. One register stage per bit of
// the shift amount: stage k shifts by 2^k when shift[k] is set, otherwise it
// passes its operand through. Every stage carries the operand, the remaining
// shift control, direction, mode, user tag, original sign bit, accumulated
// overflow and a valid bit. The whole pipeline advances together whenever the
// output register is empty or being drained, so backpressure on the output
// freezes every stage (no bubble collapsing).
//
// Modes (in_mode): 00 logical, 01 arithmetic, 10 rotate, 11 logical.
// Overflow is only reported for left shifts:
//   logical left    - a 1 bit was shifted out
//   arithmetic left - a shifted-out bit or the result MSB differs from the
//                     original sign
//
// Configuration macro:
//   SHIFT_PIPE_ROTATE_EN - when defined, mode 10 rotates (ov = 0). When
//                          undefined the rotate datapath is omitted and mode 10
//                          behaves exactly like logical mode 00.
//
// Parameters:
//   WIDTH - data width, power of two, >= 4
//   TAGW  - width of the opaque tag carried with each operand
//   SHW   - derived: shift-amount width and pipeline depth
//
// Ports:
//   clk, reset_n          - clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   - input handshake (in_ready = advance)
//   in_data, in_shift     - operand and shift amount (0..WIDTH-1)
//   in_lr                 - 1 = left, 0 = right
//   in_mode               - shift mode
//   in_tag                - tag returned unchanged with the result
//   out_valid / out_ready - output handshake
//   out_data, out_ov      - shifted result and overflow flag
//   out_tag               - tag of the result
// -----------------------------------------------------------------------------
module shift_pipe #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_lr,
    input  logic [1:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ov,
    output logic [TAGW-1:0]  out_tag
);

    // Single global advance: the pipeline moves only when the last stage is
    // empty or its result is being taken this cycle.
    logic adv;

    for (genvar k = 0; k < SHW; k++) begin : stg
        localparam int AMT = 1 << k;

        // Stage inputs (ports for stage 0, previous stage registers otherwise)
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_shift;
        logic             src_lr;
        logic [1:0]       src_mode;
        logic [TAGW-1:0]  src_tag;
        logic             src_sign;
        logic             src_ov;

        // Stage registers
        logic             q_valid;
        logic [WIDTH-1:0] q_data;
        logic [SHW-1:0]   q_shift;
        logic             q_lr;
        logic [1:0]       q_mode;
        logic [TAGW-1:0]  q_tag;
        logic             q_sign;
        logic             q_ov;

        // Combinational result of this stage
        logic [WIDTH-1:0] nxt_data;
        logic             nxt_ov;
        logic             is_arith;
        logic             is_rot;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_shift = in_shift;
            assign src_lr    = in_lr;
            assign src_mode  = in_mode;
            assign src_tag   = in_tag;
            assign src_sign  = in_data[WIDTH-1];
            assign src_ov    = 1'b0;
        end else begin : g_link
            assign src_valid = stg[k-1].q_valid;
            assign src_data  = stg[k-1].q_data;
            assign src_shift = stg[k-1].q_shift;
            assign src_lr    = stg[k-1].q_lr;
            assign src_mode  = stg[k-1].q_mode;
            assign src_tag   = stg[k-1].q_tag;
            assign src_sign  = stg[k-1].q_sign;
            assign src_ov    = stg[k-1].q_ov;
        end

        assign is_arith = (src_mode == 2'b01);
`ifdef SHIFT_PIPE_ROTATE_EN
        assign is_rot = (src_mode == 2'b10);
`else
        assign is_rot = 1'b0;
`endif

        always_comb begin
            // NOTE: every output of a combinational block gets a default
            // before any branch, otherwise an untaken path infers a latch.
            nxt_data = src_data;
            nxt_ov   = src_ov;
            if (src_shift[k]) begin
                if (src_lr) begin
                    nxt_data = src_data << AMT;
                    if (is_rot) begin
                        nxt_data = nxt_data | (src_data >> (WIDTH - AMT));
                    end else if (is_arith) begin
                        // Every original bit either leaves through the top or
                        // ends up as the final MSB, so checking the bits that
                        // leave plus the new MSB at each stage covers both
                        // overflow conditions.
                        nxt_ov = src_ov
                               | (src_data[WIDTH-1 -: AMT] != {AMT{src_sign}})
                               | (nxt_data[WIDTH-1] != src_sign);
                    end else begin
                        nxt_ov = src_ov | (|src_data[WIDTH-1 -: AMT]);
                    end
                end else begin
                    nxt_data = src_data >> AMT;
                    if (is_rot) begin
                        nxt_data = nxt_data | (src_data << (WIDTH - AMT));
                    end else if (is_arith && src_sign) begin
                        nxt_data = nxt_data | ~({WIDTH{1'b1}} >> AMT);
                    end
                end
            end
        end

        // NOTE: the datapath registers are reset along with the valid bits
        // because the output data, flag and tag must read zero in reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q_valid <= 1'b0;
                q_data  <= '0;
                q_shift <= '0;
                q_lr    <= 1'b0;
                q_mode  <= '0;
                q_tag   <= '0;
                q_sign  <= 1'b0;
                q_ov    <= 1'b0;
            end else if (adv) begin
                // NOTE: sequential state uses non-blocking assignments so all
                // stages sample their sources from before the clock edge.
                q_valid <= src_valid;
                q_data  <= nxt_data;
                q_shift <= src_shift;
                q_lr    <= src_lr;
                q_mode  <= src_mode;
                q_tag   <= src_tag;
                q_sign  <= src_sign;
                q_ov    <= nxt_ov;
            end
        end
    end

    assign out_valid = stg[SHW-1].q_valid;
    assign out_data  = stg[SHW-1].q_data;
    assign out_ov    = stg[SHW-1].q_ov;
    assign out_tag   = stg[SHW-1].q_tag;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Control carried into the last stage has no further consumer.
    logic unused_tail;
    assign unused_tail = ^{stg[SHW-1].q_shift, stg[SHW-1].q_lr,
                           stg[SHW-1].q_mode, stg[SHW-1].q_sign};

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
//
// Bench for shift_pipe at WIDTH = 16. A monitor samples the handshakes on the
// falling edge, pushes a reference result for every accepted operand and
// compares it with every result taken. The reference computes each result
// from whole-word arithmetic (double-width shifts, signed range check) rather
// than stage by stage. Directed operations also check the test-plan constants
// and the latency; later phases cover backpressure, random traffic and reset.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int TAGW  = 4;
    localparam int SHW   = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic             in_lr;
    logic [1:0]       in_mode;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ov;
    logic [TAGW-1:0]  out_tag;

    shift_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shift (in_shift),
        .in_lr    (in_lr),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ov   (out_ov),
        .out_tag  (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ov;
        logic [TAGW-1:0]  tag;
    } result_t;

    int vectors     = 0;
    int miscompares = 0;

    result_t          sb[$];
    int               n_in  = 0;
    int               n_out = 0;
    logic [WIDTH-1:0] last_data;
    logic             last_ov;
    logic [TAGW-1:0]  last_tag;
    bit               hold_pend = 0;
    result_t          hold_val;

    // Reference: whole-word shift with the mode rules applied directly.
    function automatic result_t model(input logic [WIDTH-1:0] d, input int s,
                                      input bit lr, input logic [1:0] mode,
                                      input logic [TAGW-1:0] tag);
        logic [2*WIDTH-1:0]    w;
        logic signed [WIDTH-1:0] sd;
        longint                v;
        int                    m;
        result_t               r;
        m = int'(mode);
        if (m == 3) m = 0;
`ifndef SHIFT_PIPE_ROTATE_EN
        if (m == 2) m = 0;
`endif
        r.tag = tag;
        r.ov  = 1'b0;
        sd    = d;
        if (lr) begin
            case (m)
                0: begin
                    w = {{WIDTH{1'b0}}, d} << s;
                    r.data = w[WIDTH-1:0];
                    r.ov   = (w[2*WIDTH-1:WIDTH] != '0);
                end
                1: begin
                    w = {{WIDTH{1'b0}}, d} << s;
                    r.data = w[WIDTH-1:0];
                    v = longint'(sd) * (longint'(1) << s);
                    r.ov = (v > 32767) || (v < -32768);
                end
                default: begin
                    w = {d, d} << s;
                    r.data = w[2*WIDTH-1:WIDTH];
                end
            endcase
        end else begin
            case (m)
                0: r.data = d >> s;
                1: r.data = sd >>> s;
                default: begin
                    w = {d, d} >> s;
                    r.data = w[WIDTH-1:0];
                end
            endcase
        end
        return r;
    endfunction

    // Monitor: inputs change only just after the rising edge, so the falling
    // edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        result_t exp_r;
        if (!reset_n) begin
            sb.delete();
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                vectors++;
                assert (out_valid === 1'b1 && out_data === hold_val.data &&
                        out_ov === hold_val.ov && out_tag === hold_val.tag)
                else begin
                    miscompares++;
                    $error("FAIL hold_stable: got v=%b d=%h ov=%b t=%h, want v=1 d=%h ov=%b t=%h",
                           out_valid, out_data, out_ov, out_tag,
                           hold_val.data, hold_val.ov, hold_val.tag);
                end
            end
            if (out_valid && !out_ready) begin
                vectors++;
                assert (in_ready === 1'b0)
                else begin
                    miscompares++;
                    $error("FAIL in_ready_hold: got %b, want 0", in_ready);
                end
                hold_pend     = 1;
                hold_val.data = out_data;
                hold_val.ov   = out_ov;
                hold_val.tag  = out_tag;
            end else begin
                hold_pend = 0;
            end
            if (out_valid && out_ready) begin
                vectors++;
                assert (sb.size() > 0)
                else begin
                    miscompares++;
                    $error("FAIL unexpected_output: got d=%h t=%h, want no result", out_data, out_tag);
                end
                if (sb.size() > 0) begin
                    exp_r = sb.pop_front();
                    vectors++;
                    assert (out_data === exp_r.data && out_ov === exp_r.ov && out_tag === exp_r.tag)
                    else begin
                        miscompares++;
                        $error("FAIL result: got d=%h ov=%b t=%h, want d=%h ov=%b t=%h",
                               out_data, out_ov, out_tag, exp_r.data, exp_r.ov, exp_r.tag);
                    end
                end
                last_data = out_data;
                last_ov   = out_ov;
                last_tag  = out_tag;
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, int'(in_shift), in_lr, in_mode, in_tag));
                n_in++;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One isolated operation with out_ready = 1: checks latency and result.
    task automatic run_op(input string name, input logic [WIDTH-1:0] d, input int s,
                          input bit lr, input logic [1:0] mode, input logic [TAGW-1:0] tag,
                          input logic [WIDTH-1:0] exp_d, input bit exp_ov);
        bit acc;
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = SHW'(s);
        in_lr     = lr;
        in_mode   = mode;
        in_tag    = tag;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        assert (acc && n == 4)
        else begin
            miscompares++;
            $error("FAIL %s latency: got accepted=%b cycles=%0d, want accepted=1 cycles=4", name, acc, n);
        end
        @(posedge clk);
        #1;
        vectors++;
        assert (last_data === exp_d && last_ov === exp_ov && last_tag === tag)
        else begin
            miscompares++;
            $error("FAIL %s: got d=%h ov=%b t=%h, want d=%h ov=%b t=%h",
                   name, last_data, last_ov, last_tag, exp_d, exp_ov, tag);
        end
    endtask

    // Run with out_ready = 1 and no new input until the scoreboard drains.
    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() > 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        assert (sb.size() == 0 && out_valid === 1'b0)
        else begin
            miscompares++;
            $error("FAIL %s drain: got pending=%0d out_valid=%b, want pending=0 out_valid=0",
                   name, sb.size(), out_valid);
        end
    endtask

    initial begin
        bit acc;
        int sent;
        int cyc;
        int out0;
        logic [WIDTH-1:0] exp_rot_d;
        bit               exp_rot_ov;

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_lr     = 1'b0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        assert (out_valid === 1'b0 && out_data === '0 && out_ov === 1'b0 &&
                out_tag === '0 && in_ready === 1'b1)
        else begin
            miscompares++;
            $error("FAIL reset_state: got v=%b d=%h ov=%b t=%h rdy=%b, want v=0 d=0 ov=0 t=0 rdy=1",
                   out_valid, out_data, out_ov, out_tag, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed operations
        run_op("lsl_f0_4",   16'h00F0, 4,  1, 2'b00, 4'h5, 16'h0F00, 0);
        run_op("lsl_8001_1", 16'h8001, 1,  1, 2'b00, 4'h6, 16'h0002, 1);
        run_op("lsr_8001_15",16'h8001, 15, 0, 2'b00, 4'h7, 16'h0001, 0);
        run_op("asr_8000_15",16'h8000, 15, 0, 2'b01, 4'h8, 16'hFFFF, 0);
        run_op("asl_4000_1", 16'h4000, 1,  1, 2'b01, 4'h9, 16'h8000, 1);
        run_op("asl_c000_1", 16'hC000, 1,  1, 2'b01, 4'hA, 16'h8000, 0);
        run_op("asl_8123_0", 16'h8123, 0,  1, 2'b01, 4'hB, 16'h8123, 0);
        run_op("m11_8001_1", 16'h8001, 1,  1, 2'b11, 4'hC, 16'h0002, 1);
`ifdef SHIFT_PIPE_ROTATE_EN
        exp_rot_d  = 16'h0018;
        exp_rot_ov = 1'b0;
`else
        exp_rot_d  = 16'h0010;
        exp_rot_ov = 1'b1;
`endif
        run_op("rol_8001_4", 16'h8001, 4,  1, 2'b10, 4'hD, exp_rot_d, exp_rot_ov);

        // Backpressure: 8 operands, tags 0..7, out_ready low for 6 cycles
        out0 = n_out;
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 100) begin
            out_ready = !(cyc >= 5 && cyc < 11);
            in_valid  = 1'b1;
            in_data   = WIDTH'(16'h1111 * (sent + 1) ^ 16'h8421);
            in_shift  = SHW'(sent * 3 + 1);
            in_lr     = sent[0];
            in_mode   = sent[2:1];
            in_tag    = TAGW'(sent);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        drain("backpressure");
        vectors++;
        assert (sent == 8 && n_out - out0 == 8)
        else begin
            miscompares++;
            $error("FAIL bp_count: got sent=%0d taken=%0d, want sent=8 taken=8", sent, n_out - out0);
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = WIDTH'($urandom);
            in_shift  = SHW'($urandom);
            in_lr     = 1'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = TAGW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        drain("random");

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(16'hA5A5 + i);
            in_shift = SHW'(i + 1);
            in_lr    = 1'b1;
            in_mode  = 2'b00;
            in_tag   = TAGW'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        assert (out_valid === 1'b0 && out_data === '0 && out_ov === 1'b0 &&
                out_tag === '0 && in_ready === 1'b1)
        else begin
            miscompares++;
            $error("FAIL reset_midflight: got v=%b d=%h ov=%b t=%h rdy=%b, want v=0 d=0 ov=0 t=0 rdy=1",
                   out_valid, out_data, out_ov, out_tag, in_ready);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            assert (out_valid === 1'b0)
            else begin
                miscompares++;
                $error("FAIL stale_after_reset: got out_valid=%b, want 0", out_valid);
            end
        end
        run_op("post_reset", 16'h0C03, 2, 0, 2'b01, 4'hE, 16'h0300, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
